// File: rtl/alu_seq.sv
// Registered sequential ALU: start/ready/done handshake, chained carry flag,
// multi-cycle shift-add multiply and variable-count logical shifts.
module alu_seq #(
  parameter int unsigned W    = 8,
  parameter int unsigned CNTW = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [4:0]   ALUOp,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  input  logic         c_i,
  input  logic         use_cf,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] rslt,
  output logic [W-1:0] rslt_hi,
  output logic         c_o,
  output logic         zero,
  output logic         equal,
  output logic         gt,
  output logic         lt
);

  localparam int unsigned CW = (CNTW > $clog2(W)) ? CNTW : $clog2(W);

  localparam logic [4:0] OP_DEC  = 5'b00010;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_ADD  = 5'b01101;
  localparam logic [4:0] OP_SUB  = 5'b01110;
  localparam logic [4:0] OP_AND  = 5'b01111;
  localparam logic [4:0] OP_XOR  = 5'b10000;
  localparam logic [4:0] OP_LSR  = 5'b10001;
  localparam logic [4:0] OP_RSC  = 5'b10010;
  localparam logic [4:0] OP_LSL  = 5'b10011;
  localparam logic [4:0] OP_LSC  = 5'b10100;
  localparam logic [4:0] OP_OR   = 5'b10101;
  localparam logic [4:0] OP_MUL  = 5'b11000;
  localparam logic [4:0] OP_SHLN = 5'b11001;
  localparam logic [4:0] OP_SHRN = 5'b11010;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_SHIFT} state_t;

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_a, w_a_nxt;
  logic [W-1:0]  r_acc_hi, w_acc_hi_nxt;
  logic [W-1:0]  r_acc_lo, w_acc_lo_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_dir_l, w_dir_l_nxt;
  logic [W-1:0]  r_rslt, w_rslt_nxt;
  logic [W-1:0]  r_rslt_hi, w_rslt_hi_nxt;
  logic          r_c_o, w_c_o_nxt;
  logic          r_zero, w_zero_nxt;
  logic          r_equal, w_equal_nxt;
  logic          r_gt, w_gt_nxt;
  logic          r_lt, w_lt_nxt;
  logic          r_done, w_done_nxt;

  logic            w_cin;
  logic [CNTW-1:0] w_n;
  logic [W:0]      w_sum;
  logic [2*W-1:0]  w_prod;
  logic [W-1:0]    w_res;
  logic            w_co;
  logic            w_fin;

  // One shift-add step: conditionally add A into the high half, shift the pair right.
  function automatic logic [2*W-1:0] mul_step(input logic [W-1:0] hi,
                                              input logic [W-1:0] lo,
                                              input logic [W-1:0] a);
    logic [W:0] s;
    s = {1'b0, hi} + (lo[0] ? {1'b0, a} : {(W+1){1'b0}});
    return {s, lo[W-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_cnt     <= '0;
      r_dir_l   <= 1'b0;
      r_rslt    <= '0;
      r_rslt_hi <= '0;
      r_c_o     <= 1'b0;
      r_zero    <= 1'b0;
      r_equal   <= 1'b0;
      r_gt      <= 1'b0;
      r_lt      <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_a       <= w_a_nxt;
      r_acc_hi  <= w_acc_hi_nxt;
      r_acc_lo  <= w_acc_lo_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dir_l   <= w_dir_l_nxt;
      r_rslt    <= w_rslt_nxt;
      r_rslt_hi <= w_rslt_hi_nxt;
      r_c_o     <= w_c_o_nxt;
      r_zero    <= w_zero_nxt;
      r_equal   <= w_equal_nxt;
      r_gt      <= w_gt_nxt;
      r_lt      <= w_lt_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_a_nxt       = r_a;
    w_acc_hi_nxt  = r_acc_hi;
    w_acc_lo_nxt  = r_acc_lo;
    w_cnt_nxt     = r_cnt;
    w_dir_l_nxt   = r_dir_l;
    w_rslt_nxt    = r_rslt;
    w_rslt_hi_nxt = r_rslt_hi;
    w_c_o_nxt     = r_c_o;
    w_zero_nxt    = r_zero;
    w_equal_nxt   = r_equal;
    w_gt_nxt      = r_gt;
    w_lt_nxt      = r_lt;
    w_done_nxt    = 1'b0;
    w_cin         = use_cf ? r_c_o : c_i;
    w_n           = inB[CNTW-1:0];
    w_sum         = '0;
    w_prod        = '0;
    w_res         = '0;
    w_co          = 1'b0;
    w_fin         = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_fin = 1'b1;
          case (ALUOp)
            OP_ADD: begin
              w_sum = {1'b0, inA} + {1'b0, inB} + {{W{1'b0}}, w_cin};
              w_res = w_sum[W-1:0];
              w_co  = w_sum[W];
            end
            OP_SUB: begin
              w_sum = {1'b0, inA} + {1'b0, ~inB} + {{W{1'b0}}, w_cin};
              w_res = w_sum[W-1:0];
              w_co  = w_sum[W];
            end
            OP_DEC: w_res = inA - W'(1);
            OP_AND: w_res = inA & inB;
            OP_OR:  w_res = inA | inB;
            OP_XOR: w_res = inA ^ inB;
            OP_LSR: begin w_res = {1'b0, inA[W-1:1]};  w_co = inA[0];   end
            OP_LSL: begin w_res = {inA[W-2:0], 1'b0};  w_co = inA[W-1]; end
            OP_RSC: begin w_res = {w_cin, inA[W-1:1]}; w_co = inA[0];   end
            OP_LSC: begin w_res = {inA[W-2:0], w_cin}; w_co = inA[W-1]; end
            OP_CMP: begin
              w_fin       = 1'b0;
              w_done_nxt  = 1'b1;
              w_zero_nxt  = (inA == inB);
              w_equal_nxt = (inA == inB);
              w_gt_nxt    = (inA > inB);
              w_lt_nxt    = (inA < inB);
            end
            OP_MUL: begin
              // First multiplier bit is consumed on the accept edge itself.
              w_fin        = 1'b0;
              w_prod       = mul_step('0, inB, inA);
              w_acc_hi_nxt = w_prod[2*W-1:W];
              w_acc_lo_nxt = w_prod[W-1:0];
              w_a_nxt      = inA;
              w_cnt_nxt    = CW'(W - 1);
              w_state_nxt  = S_MUL;
            end
            OP_SHLN, OP_SHRN: begin
              w_res = inA;
              if (w_n != '0) begin
                w_res = (ALUOp == OP_SHLN) ? {inA[W-2:0], 1'b0} : {1'b0, inA[W-1:1]};
                w_co  = (ALUOp == OP_SHLN) ? inA[W-1] : inA[0];
              end
              if (w_n > CNTW'(1)) begin
                w_fin        = 1'b0;
                w_acc_lo_nxt = w_res;
                w_cnt_nxt    = CW'(w_n) - CW'(1);
                w_dir_l_nxt  = (ALUOp == OP_SHLN);
                w_state_nxt  = S_SHIFT;
              end
            end
            default: begin
              w_res = '0;
              w_co  = 1'b0;
            end
          endcase
        end
      end
      S_MUL: begin
        w_prod       = mul_step(r_acc_hi, r_acc_lo, r_a);
        w_acc_hi_nxt = w_prod[2*W-1:W];
        w_acc_lo_nxt = w_prod[W-1:0];
        w_cnt_nxt    = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt   = S_IDLE;
          w_done_nxt    = 1'b1;
          w_rslt_nxt    = w_prod[W-1:0];
          w_rslt_hi_nxt = w_prod[2*W-1:W];
          w_c_o_nxt     = |w_prod[2*W-1:W];
          w_zero_nxt    = (w_prod == '0);
          w_equal_nxt   = 1'b0;
          w_gt_nxt      = 1'b0;
          w_lt_nxt      = 1'b0;
        end
      end
      S_SHIFT: begin
        w_res        = r_dir_l ? {r_acc_lo[W-2:0], 1'b0} : {1'b0, r_acc_lo[W-1:1]};
        w_co         = r_dir_l ? r_acc_lo[W-1] : r_acc_lo[0];
        w_acc_lo_nxt = w_res;
        w_cnt_nxt    = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_fin       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Common completion path for every non-CMP, non-MUL result.
    if (w_fin) begin
      w_rslt_nxt    = w_res;
      w_rslt_hi_nxt = '0;
      w_c_o_nxt     = w_co;
      w_zero_nxt    = (w_res == '0);
      w_equal_nxt   = 1'b0;
      w_gt_nxt      = 1'b0;
      w_lt_nxt      = 1'b0;
      w_done_nxt    = 1'b1;
    end
  end

  assign ready   = (r_state == S_IDLE);
  assign done    = r_done;
  assign rslt    = r_rslt;
  assign rslt_hi = r_rslt_hi;
  assign c_o     = r_c_o;
  assign zero    = r_zero;
  assign equal   = r_equal;
  assign gt      = r_gt;
  assign lt      = r_lt;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, hand-built multi-cycle sequences,
// and random ops checked against an arithmetic reference model.
module tb_alu_seq;
  localparam int unsigned W = 8;

  localparam logic [4:0] OP_DEC  = 5'b00010;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_ADD  = 5'b01101;
  localparam logic [4:0] OP_SUB  = 5'b01110;
  localparam logic [4:0] OP_AND  = 5'b01111;
  localparam logic [4:0] OP_XOR  = 5'b10000;
  localparam logic [4:0] OP_LSR  = 5'b10001;
  localparam logic [4:0] OP_RSC  = 5'b10010;
  localparam logic [4:0] OP_LSL  = 5'b10011;
  localparam logic [4:0] OP_LSC  = 5'b10100;
  localparam logic [4:0] OP_OR   = 5'b10101;
  localparam logic [4:0] OP_MUL  = 5'b11000;
  localparam logic [4:0] OP_SHLN = 5'b11001;
  localparam logic [4:0] OP_SHRN = 5'b11010;

  logic         clk, reset, start, c_i, use_cf;
  logic [4:0]   ALUOp;
  logic [W-1:0] inA, inB, rslt, rslt_hi;
  logic         ready, done, c_o, zero, equal, gt, lt;

  alu_seq #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOp(ALUOp),
    .inA(inA), .inB(inB), .c_i(c_i), .use_cf(use_cf),
    .ready(ready), .done(done), .rslt(rslt), .rslt_hi(rslt_hi),
    .c_o(c_o), .zero(zero), .equal(equal), .gt(gt), .lt(lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] op;
    logic [7:0] a, b;
    logic       ci, ucf;
    logic [7:0] r, h;
    logic       co, z, eq, gt, lt;
    int         lat;
  } vec_t;

  int         n_tests, n_fail;
  logic [7:0] m_r, m_h;
  logic       m_co;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic ci, input logic ucf, input logic [7:0] r,
                              input logic [7:0] h, input logic co, input logic z,
                              input logic eq, input logic g, input logic l, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.ci = ci; v.ucf = ucf;
    v.r = r; v.h = h; v.co = co; v.z = z; v.eq = eq; v.gt = g; v.lt = l; v.lat = lat;
    return v;
  endfunction

  // Reference model: plain integer arithmetic on the operation's definition.
  task automatic model(inout vec_t v);
    int a, b, cin, s, n, p;
    a = int'(v.a); b = int'(v.b); cin = v.ucf ? int'(m_co) : int'(v.ci);
    p = 0;
    v.r = 8'h00; v.h = 8'h00; v.co = 1'b0; v.eq = 1'b0; v.gt = 1'b0; v.lt = 1'b0; v.lat = 1;
    case (v.op)
      OP_ADD: begin s = a + b + cin;         v.r = 8'(s % 256); v.co = (s > 255); end
      OP_SUB: begin s = a + (255 - b) + cin; v.r = 8'(s % 256); v.co = (s > 255); end
      OP_DEC: v.r = 8'((a + 255) % 256);
      OP_AND: v.r = v.a & v.b;
      OP_OR:  v.r = v.a | v.b;
      OP_XOR: v.r = v.a ^ v.b;
      OP_LSR: begin v.r = 8'(a / 2);                 v.co = (a % 2 == 1); end
      OP_LSL: begin v.r = 8'((a * 2) % 256);         v.co = (a >= 128);   end
      OP_RSC: begin v.r = 8'(a / 2 + cin * 128);     v.co = (a % 2 == 1); end
      OP_LSC: begin v.r = 8'((a * 2) % 256 + cin);   v.co = (a >= 128);   end
      OP_CMP: begin
        v.r = m_r; v.h = m_h; v.co = m_co;
        v.eq = (a == b); v.gt = (a > b); v.lt = (a < b);
      end
      OP_MUL: begin
        p = a * b; v.r = 8'(p % 256); v.h = 8'(p / 256); v.co = (p >= 256); v.lat = 8;
      end
      OP_SHLN: begin
        n = b % 8;
        v.r = 8'((a << n) % 256);
        v.co = (n == 0) ? 1'b0 : 1'((a >> (8 - n)) & 1);
        v.lat = (n == 0) ? 1 : n;
      end
      OP_SHRN: begin
        n = b % 8;
        v.r = 8'(a >> n);
        v.co = (n == 0) ? 1'b0 : 1'((a >> (n - 1)) & 1);
        v.lat = (n == 0) ? 1 : n;
      end
      default: v.r = 8'h00;
    endcase
    if (v.op == OP_CMP)      v.z = (a == b);
    else if (v.op == OP_MUL) v.z = (p == 0);
    else                     v.z = (v.r == 8'h00);
  endtask

  task automatic apply(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    start = 1'b1; ALUOp = v.op; inA = v.a; inB = v.b; c_i = v.ci; use_cf = v.ucf;
    chk({tag, "_ready_in"}, int'(ready), 1);
    @(posedge clk); #1;
    start = 1'b0; ALUOp = 5'($urandom); inA = 8'($urandom); inB = 8'($urandom);
    c_i = 1'($urandom); use_cf = 1'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      chk({tag, "_busy_ready"}, int'(ready), 0);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_ready_done"}, int'(ready), 1);
    chk({tag, "_rslt"}, int'(rslt), int'(v.r));
    chk({tag, "_rslt_hi"}, int'(rslt_hi), int'(v.h));
    chk({tag, "_c_o"}, int'(c_o), int'(v.co));
    chk({tag, "_zero"}, int'(zero), int'(v.z));
    chk({tag, "_eq_gt_lt"}, int'({equal, gt, lt}), int'({v.eq, v.gt, v.lt}));
    m_r = v.r; m_h = v.h; m_co = v.co;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rslt"}, int'(rslt), 0);
    chk({tag, "_rslt_hi"}, int'(rslt_hi), 0);
    chk({tag, "_flags"}, int'({c_o, zero, equal, gt, lt}), 0);
    chk({tag, "_ready"}, int'(ready), 1);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[18];
    vec_t v;
    logic [4:0] ops[14];
    int dcnt;

    n_tests = 0; n_fail = 0;
    m_r = 8'h00; m_h = 8'h00; m_co = 1'b0;
    reset = 1'b1; start = 1'b0; ALUOp = 5'h00; inA = '0; inB = '0; c_i = 1'b0; use_cf = 1'b0;

    //            op       A      B      ci  ucf  rslt   hi     co  z   eq  gt  lt  lat
    tbl[0]  = mk(OP_ADD,  8'hFF, 8'h01, 0,  0,   8'h00, 8'h00, 1,  1,  0,  0,  0,  1);
    tbl[1]  = mk(OP_ADD,  8'h00, 8'h00, 0,  1,   8'h01, 8'h00, 0,  0,  0,  0,  0,  1);
    tbl[2]  = mk(OP_SUB,  8'h05, 8'h07, 1,  0,   8'hFE, 8'h00, 0,  0,  0,  0,  0,  1);
    tbl[3]  = mk(OP_CMP,  8'h10, 8'h20, 0,  0,   8'hFE, 8'h00, 0,  0,  0,  0,  1,  1);
    tbl[4]  = mk(OP_MUL,  8'hFF, 8'hFF, 0,  0,   8'h01, 8'hFE, 1,  0,  0,  0,  0,  8);
    tbl[5]  = mk(OP_SHLN, 8'h81, 8'h03, 0,  0,   8'h08, 8'h00, 0,  0,  0,  0,  0,  3);
    tbl[6]  = mk(OP_SHRN, 8'h81, 8'h01, 0,  0,   8'h40, 8'h00, 1,  0,  0,  0,  0,  1);
    tbl[7]  = mk(OP_SHRN, 8'h81, 8'h00, 0,  0,   8'h81, 8'h00, 0,  0,  0,  0,  0,  1);
    tbl[8]  = mk(OP_CMP,  8'h33, 8'h33, 0,  0,   8'h81, 8'h00, 0,  1,  1,  0,  0,  1);
    tbl[9]  = mk(OP_DEC,  8'h00, 8'h00, 0,  0,   8'hFF, 8'h00, 0,  0,  0,  0,  0,  1);
    tbl[10] = mk(5'b00000,8'h12, 8'h34, 1,  0,   8'h00, 8'h00, 0,  1,  0,  0,  0,  1);
    tbl[11] = mk(OP_LSC,  8'h80, 8'h00, 1,  0,   8'h01, 8'h00, 1,  0,  0,  0,  0,  1);
    tbl[12] = mk(OP_RSC,  8'h01, 8'h00, 0,  1,   8'h80, 8'h00, 1,  0,  0,  0,  0,  1);
    tbl[13] = mk(OP_MUL,  8'h00, 8'h55, 0,  0,   8'h00, 8'h00, 0,  1,  0,  0,  0,  8);
    tbl[14] = mk(OP_CMP,  8'h20, 8'h10, 0,  0,   8'h00, 8'h00, 0,  0,  0,  1,  0,  1);
    tbl[15] = mk(OP_SHLN, 8'hFF, 8'hFF, 0,  0,   8'h80, 8'h00, 1,  0,  0,  0,  0,  7);
    tbl[16] = mk(OP_XOR,  8'hA5, 8'hFF, 0,  0,   8'h5A, 8'h00, 0,  0,  0,  0,  0,  1);
    tbl[17] = mk(OP_AND,  8'hF0, 8'h0F, 0,  0,   8'h00, 8'h00, 0,  1,  0,  0,  0,  1);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_state("reset");

    for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("v%0d", i));

    // MUL with a stray start while busy, then an ADD accepted on the done edge.
    @(negedge clk);
    start = 1'b1; ALUOp = OP_MUL; inA = 8'hFF; inB = 8'hFF; c_i = 1'b0; use_cf = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("mul_busy_t%0d", k), int'({ready, done}), 0);
      if (k == 3) begin
        start = 1'b1; ALUOp = OP_ADD; inA = 8'h01; inB = 8'h01;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("mul_t8_done_ready", int'({ready, done}), 3);
    chk("mul_t8_rslt", int'(rslt), 8'h01);
    chk("mul_t8_hi", int'(rslt_hi), 8'hFE);
    chk("mul_t8_co", int'(c_o), 1);
    start = 1'b1; ALUOp = OP_ADD; inA = 8'h01; inB = 8'h02; c_i = 1'b0; use_cf = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_t9_done", int'(done), 1);
    chk("b2b_t9_rslt", int'(rslt), 8'h03);
    chk("b2b_t9_hi", int'(rslt_hi), 8'h00);
    chk("b2b_t9_co", int'(c_o), 0);
    @(posedge clk); #1;
    chk("b2b_t10_done", int'(done), 0);

    // Reset mid-MUL aborts it silently.
    @(negedge clk);
    start = 1'b1; ALUOp = OP_MUL; inA = 8'h0F; inB = 8'h0F;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_state("mid_reset");
    dcnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("mid_reset_no_done", dcnt, 0);
    m_r = 8'h00; m_h = 8'h00; m_co = 1'b0;

    ops = '{OP_ADD, OP_SUB, OP_DEC, OP_AND, OP_OR, OP_XOR, OP_LSR,
            OP_LSL, OP_RSC, OP_LSC, OP_CMP, OP_MUL, OP_SHLN, OP_SHRN};
    for (int i = 0; i < 250; i++) begin
      v.op  = ($urandom_range(0, 15) == 0) ? 5'($urandom) : ops[$urandom_range(0, 13)];
      v.a   = 8'($urandom);
      v.b   = 8'($urandom);
      v.ci  = 1'($urandom);
      v.ucf = 1'($urandom);
      model(v);
      apply(v, $sformatf("rnd%0d_op%02h", i, v.op));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 8-bit combinational datapath ALU. Adds a start/ready/done handshake, a registered flag set whose carry can chain multi-precision arithmetic, and multi-cycle ops: unsigned shift-add multiply and variable-count shifts. It sits between the register file read ports and the writeback mux, and the controller stalls on `ready`.

## Interface
- `W`, 8: datapath width in bits (W ≥ 2)
- `CNTW`, $clog2(W): shift-count width; count is `inB[CNTW-1:0]`
- `clk` input 1: single clock, all state on rising edge
- `reset` input 1: synchronous, active-high
- `start` input 1: request; accepted on an edge where `start && ready`
- `ALUOp` input 5: operation code, sampled at acceptance
- `inA`, `inB` input W: operands, sampled at acceptance
- `c_i` input 1: external carry-in
- `use_cf` input 1: 1 selects the registered carry flag as carry-in instead of `c_i`
- `ready` output 1: idle, can accept
- `done` output 1: one-cycle pulse when results and flags update
- `rslt` output W: result low word (registered)
- `rslt_hi` output W: product high word (MUL), 0 for all other ops
- `c_o`, `zero`, `equal`, `gt`, `lt` output 1: registered flags

## Operation
- States: IDLE, MUL, SHIFT. `ready` = (state == IDLE). Operands, op and carry-in (`cin` = `use_cf ? c_o : c_i`) are latched at acceptance. Input changes after acceptance and `start` while busy are ignored.
- Single-cycle ops (stay IDLE):
  - ADD 01101: {c_o,rslt} = A + B + cin
  - SUB 01110: {c_o,rslt} = A + ~B + cin. cin=1 gives A−B; c_o=1 means no borrow.
  - DEC 00010: rslt = A − 1, c_o = 0
  - AND 01111, OR 10101, XOR 10000: bitwise, c_o = 0
  - LSR 10001 / LSL 10011: one-bit logical shift, c_o = bit shifted out
  - RSC 10010 / LSC 10100: one-bit shift inserting cin, c_o = bit shifted out
  - CMP 00101, unsigned: equal = zero = (A==B), gt = (A>B), lt = (A<B). `rslt`, `rslt_hi` and `c_o` are left unchanged.
- Multi-cycle ops:
  - MUL 11000: unsigned W×W shift-add, one bit of B per cycle, exactly W cycles. {rslt_hi,rslt} = A×B; c_o = |rslt_hi; zero = (2W-bit product == 0).
  - SHLN 11001 / SHRN 11010: logical shift by n = `inB[CNTW-1:0]`, one bit per cycle, max(n,1) cycles. c_o = last bit shifted out, 0 when n = 0. n = 0 returns A unchanged.
- Flag rules for all non-CMP ops: zero = (rslt == 0), except MUL as above. equal, gt and lt clear to 0.
- Undefined ALUOp: single-cycle; rslt = 0, rslt_hi = 0, c_o = 0, zero = 1, other flags 0.
- Outputs and flags hold between ops. They change only on a `done` edge or on reset.

## Timing
- Acceptance at edge T. Single-cycle op: outputs updated and `done` = 1 in the cycle after T (latency 1).
- MUL: `ready` = 0 for the W−1 cycles following T. Outputs and `done` appear in cycle T+W.
- SHLN/SHRN: `done` in cycle T+max(n,1). `ready` is low in between.
- `ready` is 1 in every `done` cycle, so a back-to-back accept on the done edge is legal.
- `use_cf` on an op accepted in a `done` cycle sees the c_o produced by that `done`.
- Reset values (after the reset edge): `rslt`, `rslt_hi` = 0; all flags = 0; `done` = 0; `ready` = 1; state IDLE.
- Reset asserted mid-operation aborts the op with no `done` pulse. Reset has priority over `start` on the same edge.

## Test plan
- ADD A=0xFF, B=0x01, c_i=0 -> next cycle rslt=0x00, c_o=1, zero=1, done=1. Then ADD A=0x00, B=0x00 with use_cf=1 -> rslt=0x01, c_o=0.
- SUB A=0x05, B=0x07, c_i=1 -> rslt=0xFE, c_o=0, zero=0. Then CMP A=0x10, B=0x20 -> lt=1, gt=0, equal=0, zero=0, rslt still 0xFE.
- MUL A=0xFF, B=0xFF -> ready low T+1..T+7; at T+8 rslt=0x01, rslt_hi=0xFE, c_o=1, done=1. A `start` pulse at T+3 is ignored.
- SHLN A=0x81, n=3 -> done at T+3, rslt=0x08, c_o=0. SHRN A=0x81, n=1 -> done at T+1, rslt=0x40, c_o=1. SHRN n=0 -> rslt=0x81, c_o=0, done at T+1.
- Reset asserted at T+4 of a MUL -> next cycle all outputs 0, ready=1; no done pulse ever follows for that MUL.
- Back-to-back: ADD accepted on the MUL done edge -> its result appears with done at T+W+1.
